// File: rtl/soc_result_monitor.sv
`timescale 1ns/1ps
// End-of-test monitor for the single-cycle RISC-V SoC: snoops data-memory stores,
// captures a signature window, detects the tohost completion store and enforces a run timeout.
module soc_result_monitor #(
    parameter int                ADDR_W         = 32,
    parameter int                DATA_W         = 32,
    parameter logic [ADDR_W-1:0] TOHOST_ADDR    = 32'h0000_00FC,
    parameter logic [DATA_W-1:0] PASS_VALUE     = 32'd1,
    parameter logic [ADDR_W-1:0] SIG_BASE       = 32'h0000_0080,
    parameter int                SIG_WORDS      = 4,
    parameter int                TIMEOUT_CYCLES = 1000,
    parameter int                CNT_W          = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          inst_ce_i,
    input  logic                          data_ce_i,
    input  logic                          data_we_i,
    input  logic [ADDR_W-1:0]             data_addr_i,
    input  logic [DATA_W-1:0]             data_wdata_i,
    output logic                          running_o,
    output logic                          done_o,
    output logic                          pass_o,
    output logic                          timeout_o,
    output logic [DATA_W-1:0]             result_o,
    output logic [CNT_W-1:0]              cycle_cnt_o,
    output logic [CNT_W-1:0]              store_cnt_o,
    output logic [SIG_WORDS*DATA_W-1:0]   sig_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_PASS,
        S_FAIL,
        S_TIMEOUT
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    logic             store_ev;
    logic             aligned;
    logic             tohost_hit;
    logic [CNT_W-1:0] cycle_inc;
    logic [CNT_W-1:0] store_inc;

    assign store_ev   = data_ce_i & data_we_i;
    assign aligned    = (data_addr_i[1:0] == 2'b00);
    assign tohost_hit = store_ev & aligned & (data_addr_i == TOHOST_ADDR);
    assign cycle_inc  = (&cycle_cnt_o) ? cycle_cnt_o : cycle_cnt_o + CNT_W'(1);
    assign store_inc  = (&store_cnt_o) ? store_cnt_o : store_cnt_o + CNT_W'(1);

    // Terminal states fall through the default arm, which freezes every counter and capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            running_o   <= 1'b0;
            done_o      <= 1'b0;
            pass_o      <= 1'b0;
            timeout_o   <= 1'b0;
            result_o    <= '0;
            cycle_cnt_o <= '0;
            store_cnt_o <= '0;
            sig_o       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (inst_ce_i) begin
                        state     <= S_RUN;
                        running_o <= 1'b1;
                    end
                end
                S_RUN: begin
                    cycle_cnt_o <= cycle_inc;
                    if (store_ev) begin
                        store_cnt_o <= store_inc;
                    end
                    if (store_ev && aligned) begin
                        for (int i = 0; i < SIG_WORDS; i++) begin
                            if (data_addr_i == SIG_BASE + ADDR_W'(4 * i)) begin
                                sig_o[i*DATA_W +: DATA_W] <= data_wdata_i;
                            end
                        end
                    end
                    // The tohost store takes priority over a timeout landing on the same cycle.
                    if (tohost_hit) begin
                        result_o  <= data_wdata_i;
                        running_o <= 1'b0;
                        done_o    <= 1'b1;
                        if (data_wdata_i == PASS_VALUE) begin
                            state  <= S_PASS;
                            pass_o <= 1'b1;
                        end else begin
                            state  <= S_FAIL;
                        end
                    end else if (cycle_cnt_o == TIMEOUT_LAST) begin
                        state     <= S_TIMEOUT;
                        running_o <= 1'b0;
                        done_o    <= 1'b1;
                        timeout_o <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_soc_result_monitor.sv
`timescale 1ns/1ps
// Scoreboard bench for soc_result_monitor: a transaction-level model predicts each run's
// outcome, and a monitor compares the DUT state whenever done_o rises.
module tb_soc_result_monitor;

    localparam int          ADDR_W         = 32;
    localparam int          DATA_W         = 32;
    localparam int          SIG_WORDS      = 4;
    localparam int          TIMEOUT_CYCLES = 20;
    localparam int          CNT_W          = 32;
    localparam logic [31:0] TOHOST_ADDR    = 32'h0000_00FC;
    localparam logic [31:0] PASS_VALUE     = 32'd1;
    localparam logic [31:0] SIG_BASE       = 32'h0000_0080;
    localparam int          SIG_W          = SIG_WORDS * DATA_W;

    localparam logic [1:0] K_PASS    = 2'd0;
    localparam logic [1:0] K_FAIL    = 2'd1;
    localparam logic [1:0] K_TIMEOUT = 2'd2;

    typedef logic [SIG_W-1:0] chk_t;

    typedef struct packed {
        logic        ce;
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } ev_t;

    typedef struct packed {
        logic [1:0]       kind;
        logic [31:0]      result;
        logic [31:0]      cycles;
        logic [31:0]      stores;
        logic [SIG_W-1:0] sig;
    } exp_t;

    logic                clk;
    logic                rst;
    logic                inst_ce_i;
    logic                data_ce_i;
    logic                data_we_i;
    logic [ADDR_W-1:0]   data_addr_i;
    logic [DATA_W-1:0]   data_wdata_i;
    logic                running_o;
    logic                done_o;
    logic                pass_o;
    logic                timeout_o;
    logic [DATA_W-1:0]   result_o;
    logic [CNT_W-1:0]    cycle_cnt_o;
    logic [CNT_W-1:0]    store_cnt_o;
    logic [SIG_W-1:0]    sig_o;

    ev_t  stim_q[$];
    exp_t exp_q[$];
    int   n_compared;
    int   n_mismatched;

    soc_result_monitor #(
        .ADDR_W        (ADDR_W),
        .DATA_W        (DATA_W),
        .TOHOST_ADDR   (TOHOST_ADDR),
        .PASS_VALUE    (PASS_VALUE),
        .SIG_BASE      (SIG_BASE),
        .SIG_WORDS     (SIG_WORDS),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .CNT_W         (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .inst_ce_i   (inst_ce_i),
        .data_ce_i   (data_ce_i),
        .data_we_i   (data_we_i),
        .data_addr_i (data_addr_i),
        .data_wdata_i(data_wdata_i),
        .running_o   (running_o),
        .done_o      (done_o),
        .pass_o      (pass_o),
        .timeout_o   (timeout_o),
        .result_o    (result_o),
        .cycle_cnt_o (cycle_cnt_o),
        .store_cnt_o (store_cnt_o),
        .sig_o       (sig_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input chk_t actual, input chk_t expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    function automatic ev_t mk_store(input logic [31:0] addr, input logic [31:0] data);
        ev_t ev;
        ev.ce   = 1'b1;
        ev.we   = 1'b1;
        ev.addr = addr;
        ev.data = data;
        return ev;
    endfunction

    function automatic ev_t mk_idle();
        ev_t ev;
        ev = '0;
        return ev;
    endfunction

    // Random bus activity biased towards the signature window and the tohost word.
    function automatic ev_t rand_event(input bit allow_tohost);
        ev_t ev;
        int  sel;
        ev.ce   = ($urandom_range(0, 9) != 0);
        ev.we   = ($urandom_range(0, 4) != 0);
        ev.data = $urandom;
        sel     = int'($urandom_range(0, 9));
        case (sel)
            0, 1, 2, 3, 4: ev.addr = SIG_BASE + 32'(4 * $urandom_range(0, SIG_WORDS));
            5: ev.addr = SIG_BASE + 32'(4 * $urandom_range(0, SIG_WORDS - 1) + $urandom_range(1, 3));
            6: begin
                ev.addr = allow_tohost ? TOHOST_ADDR : SIG_BASE - 32'd4;
                if ($urandom_range(0, 1) == 1) ev.data = PASS_VALUE;
            end
            7: ev.addr = TOHOST_ADDR + 32'($urandom_range(1, 3));
            8: ev.addr = $urandom;
            default: ev.addr = TOHOST_ADDR + 32'd4;
        endcase
        return ev;
    endfunction

    // Walks the per-cycle transaction list of one run and returns the expected final state.
    function automatic exp_t model_run();
        exp_t e;
        ev_t  ev;
        int   idx;
        e        = '0;
        e.kind   = K_TIMEOUT;
        e.cycles = 32'(TIMEOUT_CYCLES);
        for (int k = 0; k < TIMEOUT_CYCLES; k++) begin
            ev = stim_q[k];
            if (ev.ce && ev.we) begin
                e.stores = e.stores + 32'd1;
                if (ev.addr[1:0] == 2'b00) begin
                    if (ev.addr >= SIG_BASE && ev.addr < SIG_BASE + 32'(4 * SIG_WORDS)) begin
                        idx = int'((ev.addr - SIG_BASE) >> 2);
                        e.sig[idx*DATA_W +: DATA_W] = ev.data;
                    end
                    if (ev.addr == TOHOST_ADDR) begin
                        e.kind   = (ev.data == PASS_VALUE) ? K_PASS : K_FAIL;
                        e.result = ev.data;
                        e.cycles = 32'(k + 1);
                        return e;
                    end
                end
            end
        end
        return e;
    endfunction

    task automatic drive(input ev_t ev);
        data_ce_i    = ev.ce;
        data_we_i    = ev.we;
        data_addr_i  = ev.addr;
        data_wdata_i = ev.data;
    endtask

    task automatic doReset();
        rst       = 1'b1;
        inst_ce_i = 1'b0;
        drive(mk_idle());
        #1;
        checkOutput("rst_running", chk_t'(running_o), chk_t'(0));
        checkOutput("rst_done", chk_t'(done_o), chk_t'(0));
        checkOutput("rst_pass", chk_t'(pass_o), chk_t'(0));
        checkOutput("rst_timeout", chk_t'(timeout_o), chk_t'(0));
        checkOutput("rst_result", chk_t'(result_o), chk_t'(0));
        checkOutput("rst_cycle_cnt", chk_t'(cycle_cnt_o), chk_t'(0));
        checkOutput("rst_store_cnt", chk_t'(store_cnt_o), chk_t'(0));
        checkOutput("rst_sig", chk_t'(sig_o), chk_t'(0));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Runs the prepared stim_q: idle noise, run start, per-cycle events, then frozen-state checks.
    task automatic applyStimulus(input bit do_reset, input int n_idle);
        exp_t e;
        if (do_reset) doReset();
        while (stim_q.size() < TIMEOUT_CYCLES) stim_q.push_back(mk_idle());
        repeat (3) stim_q.push_back(rand_event(1'b1));
        for (int k = 0; k < n_idle; k++) begin
            inst_ce_i = 1'b0;
            drive(rand_event(1'b1));
            @(posedge clk);
            #1;
        end
        e = model_run();
        exp_q.push_back(e);
        inst_ce_i = 1'b1;
        drive(rand_event(1'b1));
        @(posedge clk);
        #1;
        checkOutput("running_start", chk_t'(running_o), chk_t'(1));
        for (int k = 0; k < stim_q.size(); k++) begin
            inst_ce_i = 1'($urandom_range(0, 1));
            drive(stim_q[k]);
            @(posedge clk);
            #1;
        end
        inst_ce_i = 1'b0;
        drive(mk_idle());
        @(posedge clk);
        #1;
        checkOutput("done_seen_q", chk_t'(exp_q.size()), chk_t'(0));
        exp_q.delete();
        checkOutput("frz_done", chk_t'(done_o), chk_t'(1));
        checkOutput("frz_running", chk_t'(running_o), chk_t'(0));
        checkOutput("frz_pass", chk_t'(pass_o), chk_t'(e.kind == K_PASS));
        checkOutput("frz_timeout", chk_t'(timeout_o), chk_t'(e.kind == K_TIMEOUT));
        checkOutput("frz_result", chk_t'(result_o), chk_t'(e.result));
        checkOutput("frz_cycle_cnt", chk_t'(cycle_cnt_o), chk_t'(e.cycles));
        checkOutput("frz_store_cnt", chk_t'(store_cnt_o), chk_t'(e.stores));
        checkOutput("frz_sig", chk_t'(sig_o), chk_t'(e.sig));
        stim_q.delete();
    endtask

    // Monitor: on each done_o rise, pop the predicted outcome and compare the live outputs.
    initial begin
        bit   prev_done;
        int   run_cycles;
        exp_t e;
        prev_done  = 1'b0;
        run_cycles = 0;
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                prev_done  = 1'b0;
                run_cycles = 0;
            end else begin
                if (running_o === 1'b1) run_cycles++;
                if (done_o === 1'b1 && !prev_done) begin
                    if (exp_q.size() == 0) begin
                        checkOutput("unexpected_done", chk_t'(done_o), chk_t'(0));
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("mon_run_cycles", chk_t'(run_cycles), chk_t'(e.cycles));
                        checkOutput("mon_pass", chk_t'(pass_o), chk_t'(e.kind == K_PASS));
                        checkOutput("mon_timeout", chk_t'(timeout_o), chk_t'(e.kind == K_TIMEOUT));
                        checkOutput("mon_running", chk_t'(running_o), chk_t'(0));
                        checkOutput("mon_result", chk_t'(result_o), chk_t'(e.result));
                        checkOutput("mon_cycle_cnt", chk_t'(cycle_cnt_o), chk_t'(e.cycles));
                        checkOutput("mon_store_cnt", chk_t'(store_cnt_o), chk_t'(e.stores));
                        checkOutput("mon_sig", chk_t'(sig_o), chk_t'(e.sig));
                    end
                    run_cycles = 0;
                end
                prev_done = (done_o === 1'b1);
            end
        end
    end

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        rst          = 1'b0;
        inst_ce_i    = 1'b0;
        drive(mk_idle());
        @(posedge clk);
        #1;

        $display("[TB] signature capture then tohost pass");
        stim_q.push_back(mk_store(32'h80, 32'h11));
        stim_q.push_back(mk_idle());
        stim_q.push_back(mk_store(32'h84, 32'h22));
        stim_q.push_back(mk_store(32'h88, 32'h33));
        stim_q.push_back(mk_store(32'h8C, 32'h44));
        stim_q.push_back(mk_store(32'hFC, 32'h1));
        applyStimulus(1'b1, 3);

        $display("[TB] tohost fail value with later stores");
        stim_q.push_back(mk_store(32'h84, 32'hABCD));
        stim_q.push_back(mk_store(32'hFC, 32'hDEAD));
        stim_q.push_back(mk_store(32'h80, 32'h55));
        stim_q.push_back(mk_store(32'hFC, 32'h1));
        stim_q.push_back(mk_store(32'h88, 32'h66));
        applyStimulus(1'b1, 2);

        $display("[TB] timeout without tohost store");
        for (int k = 0; k < 25; k++) stim_q.push_back(rand_event(1'b0));
        applyStimulus(1'b1, 1);

        $display("[TB] tohost pass on the timeout cycle");
        for (int k = 0; k < TIMEOUT_CYCLES - 1; k++) stim_q.push_back(rand_event(1'b0));
        stim_q.push_back(mk_store(TOHOST_ADDR, PASS_VALUE));
        applyStimulus(1'b1, 2);

        $display("[TB] misaligned stores then pass");
        stim_q.push_back(mk_store(32'hFD, 32'h1));
        stim_q.push_back(mk_store(32'h81, 32'h77));
        stim_q.push_back(mk_idle());
        stim_q.push_back(mk_store(32'hFC, 32'h1));
        applyStimulus(1'b1, 5);

        $display("[TB] reset mid-run then restart");
        doReset();
        inst_ce_i = 1'b1;
        drive(mk_idle());
        @(posedge clk);
        #1;
        drive(mk_store(32'h80, 32'hA1));
        @(posedge clk);
        #1;
        drive(mk_store(32'h84, 32'hA2));
        @(posedge clk);
        #1;
        drive(mk_store(32'h88, 32'hA3));
        @(posedge clk);
        #1;
        doReset();
        stim_q.push_back(mk_store(32'h8C, 32'hB4));
        stim_q.push_back(mk_idle());
        stim_q.push_back(mk_idle());
        stim_q.push_back(mk_store(32'hFC, 32'h1));
        applyStimulus(1'b0, 2);

        $display("[TB] randomized runs");
        for (int r = 0; r < 40; r++) begin
            int len;
            len = int'($urandom_range(5, 30));
            for (int k = 0; k < len; k++) stim_q.push_back(rand_event(1'b1));
            applyStimulus(1'b1, int'($urandom_range(0, 4)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
